// File: rtl/shared_pkg.sv
// Shared types and sizes for the SPI RAM controller and its arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: RAM geometry, SPI control codes, arbiter state encoding,
// grant owner type and the packed SPI command word.
package shared_pkg;

    localparam int ADDR_SIZE = 8;
    localparam int MEM_WIDTH = 8;                 // equals ADDR_SIZE: SPI payload carries either
    localparam int MEM_DEPTH = 2 ** ADDR_SIZE;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } control_e;

    typedef enum logic [2:0] {
        ARB_IDLE = 3'd0,
        SPI_ACC  = 3'd1,
        SPI_RD   = 3'd2,
        HOST_ACC = 3'd3,
        HOST_RD  = 3'd4
    } arb_state_e;

    typedef enum logic {
        GNT_SPI  = 1'b0,
        GNT_HOST = 1'b1
    } grant_e;

    typedef struct packed {
        control_e               ctrl;
        logic [ADDR_SIZE-1:0]   payload;
    } spi_cmd_t;

    // Data commands need the RAM; address commands only update a register.
    function automatic logic is_data_cmd(input control_e c);
        return (c == WR_DATA) || (c == RD_DATA);
    endfunction

endpackage

// File: rtl/spi_ram_arbiter_cmd_buffer.sv
// One-entry holding register for SPI commands with sticky overflow flag.
// Latency: command visible (o_full) the cycle after i_load.
// Backpressure: none upstream; a load while full and not consumed is dropped and flagged.
//
// Ports: i_load/i_cmd in, i_consume frees the entry, i_err_clr clears the
// sticky flag, o_full/o_cmd present the entry, o_err_ovf reports drops.
module spi_ram_arbiter_cmd_buffer
    import shared_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  logic     i_load,
    input  spi_cmd_t i_cmd,
    input  logic     i_consume,
    input  logic     i_err_clr,
    output logic     o_full,
    output spi_cmd_t o_cmd,
    output logic     o_err_ovf
);

    logic     r_full;
    spi_cmd_t r_cmd;
    logic     r_err_ovf;
    logic     w_accept;
    logic     w_drop;

    // A consume in the same cycle frees the slot, so the new command fits.
    assign w_accept = i_load && (!r_full || i_consume);
    assign w_drop   = i_load &&  r_full && !i_consume;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full    <= 1'b0;
            r_cmd     <= '0;
            r_err_ovf <= 1'b0;
        end else begin
            if (w_accept) begin
                r_full <= 1'b1;
                r_cmd  <= i_cmd;
            end else if (i_consume) begin
                r_full <= 1'b0;
            end
            // Set has priority over clear so a drop is never lost.
            if (w_drop) begin
                r_err_ovf <= 1'b1;
            end else if (i_err_clr) begin
                r_err_ovf <= 1'b0;
            end
        end
    end

    assign o_full    = r_full;
    assign o_cmd     = r_cmd;
    assign o_err_ovf = r_err_ovf;

endmodule

// File: rtl/spi_ram_arbiter.sv
// Owns the single-port RAM; decodes SPI commands and round-robins RAM access with a host port.
// Latency: SPI write hits RAM 2 cycles after rx_valid, SPI read tx_valid 4 cycles after; host gnt 1 cycle after req, rvalid 2 after gnt.
// Backpressure: host holds req until gnt; SPI has none, a 1-entry buffer drops excess commands and sets err_ovf.
//
// Ports: i_rx_data/i_rx_valid SPI commands in, o_tx_data/o_tx_valid SPI read
// data out; i_host_* request in, o_host_gnt/o_host_rdata/o_host_rvalid out;
// o_ram_* drive the RAM, i_ram_rdata returns one cycle after a read;
// o_err_ovf sticky drop flag cleared by i_err_clr.
module spi_ram_arbiter
    import shared_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [ADDR_SIZE+1:0]   i_rx_data,
    input  logic                   i_rx_valid,
    output logic [MEM_WIDTH-1:0]   o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_host_req,
    input  logic                   i_host_we,
    input  logic [ADDR_SIZE-1:0]   i_host_addr,
    input  logic [MEM_WIDTH-1:0]   i_host_wdata,
    output logic                   o_host_gnt,
    output logic [MEM_WIDTH-1:0]   o_host_rdata,
    output logic                   o_host_rvalid,
    output logic                   o_ram_en,
    output logic                   o_ram_we,
    output logic [ADDR_SIZE-1:0]   o_ram_addr,
    output logic [MEM_WIDTH-1:0]   o_ram_wdata,
    input  logic [MEM_WIDTH-1:0]   i_ram_rdata,
    output logic                   o_err_ovf,
    input  logic                   i_err_clr
);

    arb_state_e             r_state;
    arb_state_e             w_next_state;
    grant_e                 r_last_grant;
    logic [ADDR_SIZE-1:0]   r_wr_addr;
    logic [ADDR_SIZE-1:0]   r_rd_addr;
    logic [MEM_WIDTH-1:0]   r_tx_data;
    logic                   r_tx_valid;
    logic [MEM_WIDTH-1:0]   r_host_rdata;
    logic                   r_host_rvalid;

    spi_cmd_t               w_rx_cmd;
    spi_cmd_t               w_buf_cmd;
    logic                   w_buf_full;
    logic                   w_consume;
    logic                   w_addr_cmd;
    logic                   w_data_cmd;

    assign w_rx_cmd = spi_cmd_t'(i_rx_data);

    spi_ram_arbiter_cmd_buffer u_cmd_buf (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_load    (i_rx_valid),
        .i_cmd     (w_rx_cmd),
        .i_consume (w_consume),
        .i_err_clr (i_err_clr),
        .o_full    (w_buf_full),
        .o_cmd     (w_buf_cmd),
        .o_err_ovf (o_err_ovf)
    );

    assign w_data_cmd = w_buf_full &&  is_data_cmd(w_buf_cmd.ctrl);
    assign w_addr_cmd = w_buf_full && !is_data_cmd(w_buf_cmd.ctrl);

    always_comb begin
        w_next_state = r_state;
        w_consume    = 1'b0;
        o_ram_en     = 1'b0;
        o_ram_we     = 1'b0;
        o_ram_addr   = '0;
        o_ram_wdata  = '0;
        o_host_gnt   = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                // Address commands retire here without touching the RAM,
                // so the host may still be granted in the same cycle.
                if (w_addr_cmd) begin
                    w_consume = 1'b1;
                end
                if (w_data_cmd && (!i_host_req || r_last_grant == GNT_HOST)) begin
                    w_next_state = SPI_ACC;
                end else if (i_host_req) begin
                    w_next_state = HOST_ACC;
                end
            end
            SPI_ACC: begin
                o_ram_en  = 1'b1;
                w_consume = 1'b1;
                if (w_buf_cmd.ctrl == WR_DATA) begin
                    o_ram_we     = 1'b1;
                    o_ram_addr   = r_wr_addr;
                    o_ram_wdata  = w_buf_cmd.payload;
                    w_next_state = ARB_IDLE;
                end else begin
                    o_ram_addr   = r_rd_addr;
                    w_next_state = SPI_RD;
                end
            end
            SPI_RD: begin
                w_next_state = ARB_IDLE;
            end
            HOST_ACC: begin
                o_ram_en     = 1'b1;
                o_host_gnt   = 1'b1;
                o_ram_we     = i_host_we;
                o_ram_addr   = i_host_addr;
                o_ram_wdata  = i_host_wdata;
                w_next_state = i_host_we ? ARB_IDLE : HOST_RD;
            end
            HOST_RD: begin
                w_next_state = ARB_IDLE;
            end
            default: begin
                w_next_state = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= GNT_HOST;
        end else begin
            r_state <= w_next_state;
            if (r_state == ARB_IDLE && w_next_state == SPI_ACC) begin
                r_last_grant <= GNT_SPI;
            end else if (r_state == ARB_IDLE && w_next_state == HOST_ACC) begin
                r_last_grant <= GNT_HOST;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_addr <= '0;
            r_rd_addr <= '0;
        end else if (r_state == ARB_IDLE && w_addr_cmd) begin
            if (w_buf_cmd.ctrl == WR_ADDR) begin
                r_wr_addr <= w_buf_cmd.payload;
            end else begin
                r_rd_addr <= w_buf_cmd.payload;
            end
        end
    end

    // Read data is captured in the cycle after the RAM read strobe and
    // presented with a one-cycle valid pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_data     <= '0;
            r_tx_valid    <= 1'b0;
            r_host_rdata  <= '0;
            r_host_rvalid <= 1'b0;
        end else begin
            r_tx_valid    <= (r_state == SPI_RD);
            r_host_rvalid <= (r_state == HOST_RD);
            if (r_state == SPI_RD) begin
                r_tx_data <= i_ram_rdata;
            end
            if (r_state == HOST_RD) begin
                r_host_rdata <= i_ram_rdata;
            end
        end
    end

    assign o_tx_data     = r_tx_data;
    assign o_tx_valid    = r_tx_valid;
    assign o_host_rdata  = r_host_rdata;
    assign o_host_rvalid = r_host_rvalid;

endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
Controller that owns the single-port RAM and shares it between two requesters: the SPI slave command stream (rx_data/rx_valid) and a parallel host port (req/gnt).
- Decodes SPI control codes WR_ADDR / WR_DATA / RD_ADDR / RD_DATA, holds the write and read address registers, and sequences RAM accesses.
- Returns SPI read data on tx_data/tx_valid.
- Round-robin arbitration between the two requesters.

Parameters:
MEM_DEPTH, 256, RAM depth in words (from shared_pkg).
ADDR_SIZE, 8, address width; MEM_DEPTH = 2**ADDR_SIZE.
MEM_WIDTH, 8, data width; must equal ADDR_SIZE, since the SPI payload carries both address and data.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
rx_data  in  ADDR_SIZE+2  SPI command: [9:8] control_e, [7:0] payload.
rx_valid  in  1  single-cycle pulse qualifying rx_data.
tx_data  out  MEM_WIDTH  SPI read data.
tx_valid  out  1  single-cycle pulse qualifying tx_data.
host_req  in  1  host access request; held until granted.
host_we  in  1  host write enable; 0 means read.
host_addr  in  ADDR_SIZE  host address.
host_wdata  in  MEM_WIDTH  host write data.
host_gnt  out  1  pulse in the cycle the host RAM access is issued.
host_rdata  out  MEM_WIDTH  host read data.
host_rvalid  out  1  pulse qualifying host_rdata.
ram_en  out  1  RAM access strobe.
ram_we  out  1  RAM write enable.
ram_addr  out  ADDR_SIZE  RAM address.
ram_wdata  out  MEM_WIDTH  RAM write data.
ram_rdata  in  MEM_WIDTH  RAM read data; valid 1 cycle after ram_en && !ram_we.
err_ovf  out  1  sticky flag: SPI command dropped.
err_clr  in  1  synchronous clear of err_ovf.

Behaviour:
- Reset (asynchronous, immediate): state=ARB_IDLE; wr_addr=rd_addr=0; cmd buffer empty; last_grant=HOST.
  - Outputs: tx_data=0, tx_valid=0, host_rdata=0, host_rvalid=0, err_ovf=0.
  - ram_en, ram_we, host_gnt decode from state, so they drop to 0 at reset assertion, including reset mid-access.
- SPI command buffer, 1 entry:
  - rx_valid loads {ctrl, payload} on that edge.
  - rx_valid while full and not consumed in the same cycle: new command dropped, err_ovf set.
  - Consume and load in the same cycle is legal: no overflow.
  - err_clr and overflow in the same cycle: set wins.
- State machine (arb_state_e): ARB_IDLE, SPI_ACC, SPI_RD, HOST_ACC, HOST_RD.
- ARB_IDLE with buffer holding WR_ADDR or RD_ADDR:
  - payload goes to wr_addr or rd_addr; buffer consumed; stay in ARB_IDLE.
  - Host may be granted in the same cycle, since no RAM use is needed.
- ARB_IDLE with a data command (spi_p), host_req, or both:
  - Only spi_p → SPI_ACC; only host_req → HOST_ACC.
  - Both → the requester not equal to last_grant; last_grant updated on entry.
- SPI_ACC:
  - ram_en=1; buffer consumed.
  - WR_DATA: ram_we=1, ram_addr=wr_addr, ram_wdata=payload → ARB_IDLE.
  - RD_DATA: ram_we=0, ram_addr=rd_addr → SPI_RD.
- SPI_RD: tx_data<=ram_rdata; tx_valid=1 the following cycle for exactly 1 cycle → ARB_IDLE.
- HOST_ACC:
  - ram_en=1, host_gnt=1, ram_we=host_we, ram_addr=host_addr, ram_wdata=host_wdata.
  - Write → ARB_IDLE; read → HOST_RD.
- HOST_RD: host_rdata<=ram_rdata; host_rvalid=1 the following cycle for 1 cycle → ARB_IDLE.
- Latency, SPI read: rx_valid at cycle 0 → buffer full at 1 → SPI_ACC at 2 → SPI_RD at 3 → tx_valid at 4.
- Latency, SPI write: ram write at cycle 2.
- Worst-case SPI wait is one host read (3 cycles). SPI commands arrive ≥10 clk apart, so overflow indicates a protocol error.
- Addresses are not auto-incremented. RD_DATA without a prior RD_ADDR reads address 0. Address wrap is inherent (ADDR_SIZE bits).
- ram_* outputs are 0 in every state that drives no access.

Decomposition:
- shared_pkg additions:
  - arb_state_e (3-bit enum, distinct from the slave's state_e).
  - grant_e {GNT_SPI, GNT_HOST}.
- Reuse control_e, MEM_DEPTH, ADDR_SIZE and MEM_WIDTH from shared_pkg.
- One sub-module: spi_cmd_buffer (1-entry register with full flag, consume input and overflow output).

Test Plan:
- Reset, then SPI WR_ADDR 0x2A, then WR_DATA 0x5C → one cycle with ram_en=1, ram_we=1, ram_addr=0x2A, ram_wdata=0x5C.
- SPI RD_ADDR 0x2A, then RD_DATA (RAM model returns 0x5C) → tx_valid exactly 4 cycles after the RD_DATA rx_valid, with tx_data=0x5C.
- host_req read of addr 0x10 (RAM holds 0xA5) → host_gnt 1 cycle later, then host_rvalid with host_rdata=0xA5 two cycles after grant.
- host_req held continuously with SPI WR_DATA pending in the same ARB_IDLE cycle, last_grant=HOST → SPI served first; next ARB_IDLE grants host; grants alternate under continuous contention.
- Two rx_valid pulses 1 cycle apart while a host read holds the RAM → second command dropped, err_ovf=1 and stays set; err_clr pulse → err_ovf=0.
- rst_n asserted during HOST_ACC → ram_en=0 and host_gnt=0 immediately; state, addresses and the sticky flag return to reset values; the first post-reset RD_DATA reads addr 0.
